// File: rtl/and16_rr_arbiter.sv
// Round-robin arbiter sharing one 16-bit bitwise AND datapath among NREQ requesters.
// Latency: grant is combinational; RESULT/DONE appear two cycles after the granted request.
// Backpressure: none; one operation accepted per clock, requesters hold REQ until granted.
//
// Ports:
//   CLK, RST_N     clock and synchronous active-low reset
//   REQ  [NREQ]    per-requester request, held until GNT
//   A_IN/B_IN      16-bit operand slices, requester i at [16*i +: 16]
//   GNT  [NREQ]    one-hot combinational grant (zero while in reset)
//   RESULT [16]    registered AND of the last completed operation
//   DONE [NREQ]    one-cycle one-hot pulse tagging RESULT with its requester
//   BUSY           operand stage holds a valid operation

module and16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] out
);
  assign out = a & b;
endmodule

module and16_rr_arbiter #(
  parameter int NREQ = 4,  // 2..8
  parameter int PW   = 3   // 2**PW >= NREQ
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [NREQ-1:0]      REQ,
  input  logic [16*NREQ-1:0]   A_IN,
  input  logic [16*NREQ-1:0]   B_IN,
  output logic [NREQ-1:0]      GNT,
  output logic [15:0]          RESULT,
  output logic [NREQ-1:0]      DONE,
  output logic                 BUSY
);

  // Round-robin pointer and pipeline registers
  logic [PW-1:0]   pri_q,    pri_d;
  logic            op_vld_q, op_vld_d;
  logic [15:0]     op_a_q,   op_a_d;
  logic [15:0]     op_b_q,   op_b_d;
  logic [PW-1:0]   tag_q,    tag_d;
  logic [15:0]     res_q,    res_d;
  logic [NREQ-1:0] done_q,   done_d;

  logic [NREQ-1:0] gnt;
  logic [PW-1:0]   gnt_idx;
  logic            gnt_any;
  logic [15:0]     and_out;

  // Arbitration: scan offsets 0..NREQ-1 from the pointer; the first requesting
  // index wins. Each offset maps to exactly one index, so at most one bit is set.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!gnt_any && REQ[j] && (((int'(pri_q) + k) % NREQ) == j)) begin
          gnt[j]  = 1'b1;
          gnt_idx = PW'(j);
          gnt_any = 1'b1;
        end
      end
    end
    // Nothing may be accepted while reset is asserted.
    if (!RST_N) begin
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
    end
  end

  // Next-state: operand capture on grant, result capture one cycle later.
  always_comb begin
    pri_d    = pri_q;
    op_vld_d = gnt_any;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    tag_d    = tag_q;
    res_d    = res_q;
    done_d   = '0;

    if (gnt_any) begin
      tag_d = gnt_idx;
      pri_d = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
      for (int j = 0; j < NREQ; j++) begin
        if (gnt[j]) begin
          op_a_d = A_IN[16*j +: 16];
          op_b_d = B_IN[16*j +: 16];
        end
      end
    end

    if (op_vld_q) begin
      res_d = and_out;
      for (int j = 0; j < NREQ; j++) begin
        if (tag_q == PW'(j)) begin
          done_d[j] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pri_q    <= '0;
      op_vld_q <= 1'b0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      tag_q    <= '0;
      res_q    <= '0;
      done_q   <= '0;
    end else begin
      pri_q    <= pri_d;
      op_vld_q <= op_vld_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      tag_q    <= tag_d;
      res_q    <= res_d;
      done_q   <= done_d;
    end
  end

  // The single shared AND datapath, fed straight from the operand register.
  and16 u_and16 (
    .a   (op_a_q),
    .b   (op_b_q),
    .out (and_out)
  );

  assign GNT    = gnt;
  assign RESULT = res_q;
  assign DONE   = done_q;
  assign BUSY   = op_vld_q;

endmodule
